// File: rtl/picoramsoc_memarb_pkg.sv
// Shared encodings for the RAM SoC single-port SRAM arbiter:
// FSM states and requester port identifiers.
package picoramsoc_memarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_e;

endpackage

// File: rtl/picoramsoc_memarb_rr_arb.sv
// Combinational two-way round-robin picker: on a tie the port that was
// not granted last wins, otherwise the single requester wins.
module picoramsoc_rr_arb
    import picoramsoc_memarb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_e   last,
    output logic       gnt_valid,
    output port_id_e   gnt_id
);

    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            gnt_id = (last == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end else begin
            gnt_id = req[PORT_DATA] ? PORT_DATA : PORT_INSTR;
        end
    end

endmodule

// File: rtl/picoramsoc_memarb.sv
// Shares one single-port SRAM between the CPU fetch and data buses with
// round-robin arbitration and a fixed IDLE/ISSUE/RESP two-cycle latency.
module picoramsoc_memarb
    import picoramsoc_memarb_pkg::*;
#(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_valid,
    input  logic [31:0] instr_addr,
    output logic        instr_ready,
    output logic [31:0] instr_rdata,

    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,

    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [21:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * WORDS);

    arb_state_e state_q, state_d;
    port_id_e   last_q;
    logic [1:0] eligible;
    logic [1:0] req;
    logic       gnt_valid;
    port_id_e   gnt_id;
    logic       take_grant;

    assign eligible[PORT_INSTR] = instr_valid && (instr_addr < ADDR_LIMIT);
    assign eligible[PORT_DATA]  = mem_valid   && (mem_addr   < ADDR_LIMIT);

    // In RESP the served port still shows valid for the finished access.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req = eligible;
        if (state_q == ST_RESP) begin
            req[last_q] = 1'b0;
        end
    end

    picoramsoc_rr_arb u_rr_arb (
        .req       (req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        take_grant = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                take_grant = gnt_valid;
                state_d    = gnt_valid ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // last_q doubles as the id of the access in flight; SRAM-facing outputs
    // are registered so no request input reaches the macro combinationally.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= PORT_INSTR;
            ram_en    <= 1'b0;
            ram_wen   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state_q <= state_d;
            ram_en  <= take_grant;
            ram_wen <= '0;
            if (take_grant) begin
                last_q <= gnt_id;
                if (gnt_id == PORT_DATA) begin
                    ram_addr  <= mem_addr[23:2];
                    ram_wdata <= mem_wdata;
                    ram_wen   <= mem_wstrb;
                end else begin
                    ram_addr  <= instr_addr[23:2];
                    ram_wdata <= '0;
                end
            end
        end
    end

    assign instr_ready = (state_q == ST_RESP) && (last_q == PORT_INSTR);
    assign mem_ready   = (state_q == ST_RESP) && (last_q == PORT_DATA);
    assign instr_rdata = instr_ready ? ram_rdata : '0;
    assign mem_rdata   = mem_ready   ? ram_rdata : '0;

endmodule

// File: tb/tb_picoramsoc_memarb.sv
// Self-checking bench for picoramsoc_memarb: directed scenarios with literal
// expectations plus a per-cycle schedule-based reference model.
module tb_picoramsoc_memarb;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr_addr;
    logic        instr_ready;
    logic [31:0] instr_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    picoramsoc_memarb #(.WORDS(4096)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready),
        .instr_rdata (instr_rdata),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ram_en      (ram_en),
        .ram_wen     (ram_wen),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 'h40) ? 32'h0000_0013 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // SRAM macro: one-cycle read latency, byte write enables, read-first.
    logic [31:0] sram [0:4095];
    bit          sram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_word(i);
            sram_loaded <= 1'b1;
        end else if (ram_en) begin
            ram_rdata <= sram[ram_addr[11:0]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) sram[ram_addr[11:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each grant decision at cycle n schedules the SRAM
    // strobe for n+1 and ready for n+2; only the other port may be granted
    // at n+2, anyone from n+3.
    initial begin : model
        int          mc, en_cyc, resp_cyc, next_any;
        bit          m_last, m_port, m_write, e_i, e_m, p, x_i, x_m;
        logic [21:0] m_addr;
        logic [3:0]  m_wen;
        logic [31:0] m_wdata, m_rd;
        logic [31:0] shadow [0:4095];
        for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
        mc = 0; en_cyc = -1; resp_cyc = -1; next_any = 0;
        m_last = 1'b0; m_port = 1'b0; m_write = 1'b0;
        m_addr = '0; m_wen = '0; m_wdata = '0; m_rd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_cyc = -1; resp_cyc = -1; next_any = 0; m_last = 1'b0;
            end else begin
                if (mc == en_cyc) begin
                    if (m_write) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wen[b]) shadow[m_addr[11:0]][8*b +: 8] = m_wdata[8*b +: 8];
                    end else begin
                        m_rd = shadow[m_addr[11:0]];
                    end
                end
                check("m_ram_en", ram_en, (mc == en_cyc));
                if (mc == en_cyc) begin
                    check("m_ram_addr", ram_addr, m_addr);
                    check("m_ram_wen", ram_wen, m_wen);
                    if (m_port) check("m_ram_wdata", ram_wdata, m_wdata);
                end
                x_i = (mc == resp_cyc) && !m_port;
                x_m = (mc == resp_cyc) && m_port;
                check("m_instr_ready", instr_ready, x_i);
                check("m_mem_ready", mem_ready, x_m);
                if (x_i) check("m_instr_rdata", instr_rdata, m_rd);
                else     check("m_instr_rdata_idle", instr_rdata, 32'h0);
                if (x_m && !m_write) check("m_mem_rdata", mem_rdata, m_rd);
                else if (!x_m)       check("m_mem_rdata_idle", mem_rdata, 32'h0);

                e_i = instr_valid && (instr_addr < 32'h4000);
                e_m = mem_valid && (mem_addr < 32'h4000);
                if (mc == resp_cyc) begin
                    if (m_port) e_m = 1'b0;
                    else        e_i = 1'b0;
                end else if (mc < next_any) begin
                    e_i = 1'b0;
                    e_m = 1'b0;
                end
                if (e_i || e_m) begin
                    p = (e_i && e_m) ? !m_last : e_m;
                    en_cyc = mc + 1; resp_cyc = mc + 2; next_any = mc + 3;
                    m_last = p; m_port = p;
                    if (p) begin
                        m_addr = mem_addr[23:2]; m_wen = mem_wstrb;
                        m_wdata = mem_wdata; m_write = (mem_wstrb != 4'h0);
                    end else begin
                        m_addr = instr_addr[23:2]; m_wen = 4'h0;
                        m_wdata = 32'h0; m_write = 1'b0;
                    end
                end
            end
            mc++;
        end
    end

    // Waits for one port's ready, then drops its valid after the ready cycle.
    task automatic run_one(input bit port, input int max, output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = '0;
        for (int i = 0; i <= max; i++) begin
            @(negedge clk);
            if (port ? mem_ready : instr_ready) begin
                lat = i;
                rd  = port ? mem_rdata : instr_rdata;
                break;
            end
        end
        tick();
        if (port) mem_valid = 1'b0;
        else      instr_valid = 1'b0;
    endtask

    task automatic observe(input int cycles, input bit drop_i, input bit drop_m,
                           output int fi, output int fm, output int ci, output int cm, output int ce);
        fi = -1; fm = -1; ci = 0; cm = 0; ce = 0;
        for (int i = 0; i < cycles; i++) begin
            bit ri, rm;
            @(negedge clk);
            ri = instr_ready;
            rm = mem_ready;
            if (ri) begin ci++; if (fi < 0) fi = i; end
            if (rm) begin cm++; if (fm < 0) fm = i; end
            if (ram_en) ce++;
            tick();
            if (ri && drop_i) instr_valid = 1'b0;
            if (rm && drop_m) mem_valid = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int lat, fi, fm, ci, cm, ce;
        logic [31:0] rd;
        reset = 1'b1;
        instr_valid = 1'b0; instr_addr = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (2) tick();
        check("rst_ram_en", ram_en, 32'h0);
        check("rst_instr_ready", instr_ready, 32'h0);
        check("rst_mem_ready", mem_ready, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Lone fetch of 0x100 -> word 0x40.
        instr_valid = 1'b1; instr_addr = 32'h100;
        @(negedge clk); check("fetch_c0_en", ram_en, 32'h0);
        @(negedge clk); check("fetch_c1_en", ram_en, 32'h1);
        check("fetch_c1_addr", ram_addr, 32'h40);
        @(negedge clk); check("fetch_c2_ready", instr_ready, 32'h1);
        check("fetch_c2_rdata", instr_rdata, 32'h13);
        check("fetch_c2_mem_ready", mem_ready, 32'h0);
        tick(); instr_valid = 1'b0;
        repeat (3) tick();

        // Byte write to 0x204; inputs changed after grant must not matter.
        mem_valid = 1'b1; mem_addr = 32'h204; mem_wstrb = 4'b0010; mem_wdata = 32'h0000_AB00;
        @(negedge clk);
        tick(); mem_addr = 32'h300; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
        @(negedge clk);
        check("wr_c1_en", ram_en, 32'h1);
        check("wr_c1_wen", ram_wen, 32'h2);
        check("wr_c1_addr", ram_addr, 32'h81);
        check("wr_c1_wdata", ram_wdata, 32'h0000_AB00);
        @(negedge clk); check("wr_c2_ready", mem_ready, 32'h1);
        tick(); mem_valid = 1'b0; mem_addr = 32'h204; mem_wstrb = 4'h0; mem_wdata = '0;
        tick();
        mem_valid = 1'b1;
        run_one(1'b1, 6, lat, rd);
        check("rd_lat", lat, 32'd2);
        check("rd_byte1", rd[15:8], 32'hAB);
        check("rd_word", rd, 32'hC0DE_AB81);
        repeat (3) tick();

        // Held valid through ready: exactly one pulse, one SRAM access.
        instr_valid = 1'b1; instr_addr = 32'h100;
        observe(8, 1'b1, 1'b0, fi, fm, ci, cm, ce);
        check("held_first", fi, 32'd2);
        check("held_count", ci, 32'd1);
        check("held_en_count", ce, 32'd1);
        repeat (2) tick();

        // Top word in range, first word out of range.
        instr_valid = 1'b1; instr_addr = 32'h3FFC;
        run_one(1'b0, 6, lat, rd);
        check("top_lat", lat, 32'd2);
        check("top_rdata", rd, 32'hC0DE_0FFF);
        repeat (2) tick();
        mem_valid = 1'b1; mem_addr = 32'h4000;
        observe(6, 1'b0, 1'b0, fi, fm, ci, cm, ce);
        check("edge_oor_ready", cm, 32'd0);
        check("edge_oor_en", ce, 32'd0);
        mem_valid = 1'b0;
        repeat (2) tick();

        // Far out-of-range data request alongside a fetch.
        mem_valid = 1'b1; mem_addr = 32'h0200_0008;
        instr_valid = 1'b1; instr_addr = 32'h100;
        observe(10, 1'b1, 1'b0, fi, fm, ci, cm, ce);
        check("oor_fetch_lat", fi, 32'd2);
        check("oor_mem_ready", cm, 32'd0);
        check("oor_en_count", ce, 32'd1);
        mem_valid = 1'b0;
        repeat (3) tick();

        // Reset asserted during ISSUE aborts the fetch.
        instr_valid = 1'b1; instr_addr = 32'h100;
        @(negedge clk);
        tick(); #1;
        reset = 1'b1;
        #1;
        check("rsti_ram_en", ram_en, 32'h0);
        check("rsti_ram_addr", ram_addr, 32'h0);
        check("rsti_ram_wen", ram_wen, 32'h0);
        check("rsti_ram_wdata", ram_wdata, 32'h0);
        check("rsti_instr_ready", instr_ready, 32'h0);
        check("rsti_instr_rdata", instr_rdata, 32'h0);
        @(negedge clk); check("rsti_no_ready", instr_ready, 32'h0);
        tick(); reset = 1'b0;
        run_one(1'b0, 6, lat, rd);
        check("rsti_retry_lat", lat, 32'd2);
        check("rsti_retry_rdata", rd, 32'h13);
        repeat (3) tick();

        // Contention straight from reset: data first, then alternation.
        reset = 1'b1; tick(); reset = 1'b0;
        instr_valid = 1'b1; instr_addr = 32'h100;
        mem_valid = 1'b1; mem_addr = 32'h204; mem_wstrb = 4'h0;
        observe(12, 1'b0, 1'b0, fi, fm, ci, cm, ce);
        check("cont_mem_first", fm, 32'd2);
        check("cont_instr_first", fi, 32'd4);
        check("cont_mem_count", cm, 32'd3);
        check("cont_instr_count", ci, 32'd2);
        instr_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
